demux1to4_buffered: RTL and testbench
=====================================

DEMUX1TO4_BUFFERED -- requirements
Module: demux1to4_buffered

Interface
REQ-001 Parameter WIDTH, default 4: data width of the input and each output channel.
REQ-002 The block SHALL use one clock and asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts input word this cycle.
REQ-007 in_data  input  WIDTH  input word.
REQ-008 in_sel  input  2  destination channel, 0..3.
REQ-009 out_valid  output  4  bit i set: channel i head word present.
REQ-010 out_ready  input  4  bit i set: consumer i takes head word.
REQ-011 out_data0..out_data3  output  WIDTH each  head word of channel 0..3.

Function
REQ-012 Each channel SHALL have an independent 2-entry FIFO: storage, 1-bit write pointer, 1-bit read pointer, 2-bit count 0..2.
REQ-013 in_ready SHALL be combinational: 1 when count[in_sel] < 2, else 0. No pass-through when full, even if out_ready[in_sel]=1.
REQ-014 Push: in_valid & in_ready at a rising edge SHALL write in_data to channel in_sel at its write pointer, toggle that pointer, count +1.
REQ-015 in_data and in_sel SHALL be ignored while in_valid=0; in_sel SHALL only route, never modify data.
REQ-016 out_valid[i] SHALL equal (count[i] != 0); out_data_i SHALL show storage at read pointer i, driven from registers only.
REQ-017 Pop: out_valid[i] & out_ready[i] at a rising edge SHALL toggle read pointer i, count -1.
REQ-018 Latency: a word pushed at edge k SHALL be visible on out_data_i with out_valid[i]=1 immediately after edge k. There is no same-cycle bypass when empty.
REQ-019 Simultaneous push and pop on the same channel (count 1) SHALL leave count unchanged and advance both pointers.
REQ-020 Pointer wrap: 1-bit pointers SHALL toggle 1->0 with no special handling. Ordering within a channel SHALL be strictly FIFO.
REQ-021 Channels SHALL operate independently: pops on any subset of channels are allowed in the same cycle as a push to any channel.
REQ-022 Head-of-line: when channel in_sel is full, in_ready=0 even if other channels have space. The held word SHALL be accepted on the first edge after space frees.
REQ-023 out_ready[i] while out_valid[i]=0 SHALL have no effect. Count SHALL never exceed 2 or drop below 0.
REQ-024 out_data_i content while out_valid[i]=0 is don't-care for consumers, but SHALL hold the last stored value, never X.

Reset
REQ-025 rst_n low SHALL immediately and asynchronously clear: all counts, all pointers, and all storage to 0.
REQ-026 During reset, out_valid=4'b0000 and out_data0..3=0; in_ready=1.
REQ-027 rst_n deassertion is synchronised externally to clk. The first push is possible at the first rising edge with rst_n high.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words. No pop SHALL be signalled for them.

Verification
REQ-029 Basic route: after reset, push 4'hA sel=2 with out_ready=0 -> next cycle out_valid=4'b0100, out_data2=4'hA; others remain 0.
REQ-030 Full and backpressure: push 4'h1 then 4'h2 to sel=1 with out_ready=0 -> out_valid[1]=1, count 2, in_ready=0 for sel=1. Set out_ready[1]=1 -> pops 4'h1 then 4'h2 in order, then out_valid[1]=0.
REQ-031 Simultaneous push and pop: channel 0 holds 4'h3; push 4'h4 to sel=0 with out_ready[0]=1 -> next cycle out_data0=4'h4, out_valid[0]=1, count stays 1.
REQ-032 Head-of-line: channel 3 full; in_sel=3, in_valid=1 -> in_ready=0. Same cycle, switch to in_sel=0 -> in_ready=1 and the word lands in channel 0.
REQ-033 Reset mid-operation: fill channels 0 and 2, pulse rst_n low between clock edges -> out_valid=0 and out_data*=0 immediately. After release, the first push to sel=2 appears alone.
REQ-034 Random stress: 10k cycles of random in_valid, in_sel and out_ready against a per-channel queue model -> zero data or order mismatches, and count never outside 0..2.

Source files
------------

// File: rtl/demux1to4_buffered.sv
// 1-to-4 demultiplexer with an independent 2-entry FIFO behind each output channel.
// Input is head-of-line blocked: a word for a full channel stalls even if others have room.
module demux1to4_buffered #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
);

    logic [WIDTH-1:0] r_mem   [4][2];
    logic             r_wptr  [4];
    logic             r_rptr  [4];
    logic [1:0]       r_count [4];

    logic [3:0]       w_push;
    logic [3:0]       w_pop;
    logic [WIDTH-1:0] w_head  [4];

    // Readiness depends only on the selected channel, so a full channel blocks the input.
    assign in_ready = (r_count[in_sel] < 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            assign w_push[gi]    = in_valid & in_ready & (in_sel == 2'(gi));
            assign out_valid[gi] = (r_count[gi] != 2'd0);
            assign w_pop[gi]     = out_valid[gi] & out_ready[gi];
            assign w_head[gi]    = r_mem[gi][r_rptr[gi]];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi][0] <= '0;
                    r_mem[gi][1] <= '0;
                    r_wptr[gi]   <= 1'b0;
                    r_rptr[gi]   <= 1'b0;
                    r_count[gi]  <= 2'd0;
                end else begin
                    if (w_push[gi]) begin
                        r_mem[gi][r_wptr[gi]] <= in_data;
                        r_wptr[gi]            <= ~r_wptr[gi];
                    end
                    if (w_pop[gi]) begin
                        r_rptr[gi] <= ~r_rptr[gi];
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count[gi] <= r_count[gi] + 2'd1;
                        2'b01:   r_count[gi] <= r_count[gi] - 2'd1;
                        default: r_count[gi] <= r_count[gi];
                    endcase
                end
            end
        end
    endgenerate

    assign out_data0 = w_head[0];
    assign out_data1 = w_head[1];
    assign out_data2 = w_head[2];
    assign out_data3 = w_head[3];

endmodule

// File: tb/tb_demux1to4_buffered.sv
// Self-checking bench: directed scenarios then random stress against per-channel queue models.
module tb_demux1to4_buffered;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;

    logic [WIDTH-1:0] model [4][$];
    int numChecks = 0;
    int numFails  = 0;

    demux1to4_buffered #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] dataOf(input int ch);
        case (ch)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    // Compare every visible output against the queue model for the current inputs.
    task automatic checkAll();
        logic [3:0] expValid;
        for (int c = 0; c < 4; c++) expValid[c] = (model[c].size() != 0);
        checkOutput("in_ready", 32'(in_ready), 32'(model[in_sel].size() < 2));
        checkOutput("out_valid", 32'(out_valid), 32'(expValid));
        for (int c = 0; c < 4; c++)
            if (expValid[c]) checkOutput($sformatf("out_data%0d", c), 32'(dataOf(c)), 32'(model[c][0]));
    endtask

    // Called at a falling edge: drive, check, clock once, update the model.
    task automatic applyStimulus(input logic v, input logic [1:0] sel,
                                 input logic [WIDTH-1:0] data, input logic [3:0] rdy);
        logic [3:0] popMask;
        logic       accept;
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        out_ready = rdy;
        #1;
        checkAll();
        for (int c = 0; c < 4; c++) popMask[c] = rdy[c] && (model[c].size() != 0);
        accept = v && (model[sel].size() < 2);
        @(posedge clk);
        for (int c = 0; c < 4; c++) if (popMask[c]) void'(model[c].pop_front());
        if (accept) model[sel].push_back(data);
        for (int c = 0; c < 4; c++)
            if (model[c].size() > 2) checkOutput("model_count_range", 32'(model[c].size()), 32'd2);
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
        checkOutput({tag, "_data0"}, 32'(out_data0), 32'd0);
        checkOutput({tag, "_data1"}, 32'(out_data1), 32'd0);
        checkOutput({tag, "_data2"}, 32'(out_data2), 32'd0);
        checkOutput({tag, "_data3"}, 32'(out_data3), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0;
        #2;
        checkResetOutputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Basic route to channel 2
        applyStimulus(1, 2'd2, 4'hA, 4'b0000);
        #1;
        checkOutput("route_valid", 32'(out_valid), 32'h4);
        checkOutput("route_data2", 32'(out_data2), 32'hA);
        checkOutput("route_data0", 32'(out_data0), 32'h0);
        applyStimulus(0, 2'd0, 4'h0, 4'b0100);

        // Fill channel 1 then drain in order
        applyStimulus(1, 2'd1, 4'h1, 4'b0000);
        applyStimulus(1, 2'd1, 4'h2, 4'b0000);
        in_sel = 2'd1; #1;
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 2'd1, 4'h7, 4'b0010);
        checkOutput("drain_second", 32'(out_data1), 32'h2);
        applyStimulus(0, 2'd1, 4'h0, 4'b0010);
        applyStimulus(0, 2'd1, 4'h0, 4'b0010);
        checkOutput("drained_valid1", 32'(out_valid[1]), 32'd0);

        // Simultaneous push and pop on channel 0
        applyStimulus(1, 2'd0, 4'h3, 4'b0000);
        applyStimulus(1, 2'd0, 4'h4, 4'b0001);
        checkOutput("pushpop_data0", 32'(out_data0), 32'h4);
        checkOutput("pushpop_valid0", 32'(out_valid[0]), 32'd1);
        applyStimulus(1, 2'd0, 4'h5, 4'b0000);
        checkOutput("pushpop_count_one", 32'(in_ready), 32'd0);
        applyStimulus(0, 2'd0, 4'h0, 4'b0001);
        applyStimulus(0, 2'd0, 4'h0, 4'b0001);

        // Head-of-line blocking on channel 3, redirected to channel 0
        applyStimulus(1, 2'd3, 4'hC, 4'b0000);
        applyStimulus(1, 2'd3, 4'hD, 4'b0000);
        in_valid = 1'b1; in_sel = 2'd3; in_data = 4'hE; #1;
        checkOutput("hol_blocked", 32'(in_ready), 32'd0);
        applyStimulus(1, 2'd0, 4'hE, 4'b0000);
        checkOutput("hol_landed0", 32'(out_data0), 32'hE);
        checkOutput("hol_ch3_head", 32'(out_data3), 32'hC);

        // Asynchronous reset mid-operation
        applyStimulus(1, 2'd2, 4'h9, 4'b0000);
        in_valid = 1'b0; #2;
        rst_n = 1'b0; #1;
        for (int c = 0; c < 4; c++) model[c].delete();
        checkResetOutputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 2'd2, 4'h6, 4'b0000);
        #1;
        checkOutput("post_reset_valid", 32'(out_valid), 32'h4);
        checkOutput("post_reset_data2", 32'(out_data2), 32'h6);

        // Random stress
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          WIDTH'($urandom), 4'($urandom & $urandom));
        end
        #1;
        checkAll();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
